// File: rtl/bcd_updown_stopwatch.sv
// rtl/bcd_updown_stopwatch.sv - prescaled BCD up/down stopwatch with run/stop/lap FSM, preset load and lap freeze
module bcd_updown_stopwatch #(
    parameter int DIGITS    = 4,
    parameter int MAX_COUNT = 9999,
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_HZ   = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_run_stop,
    input  logic                i_clear,
    input  logic                i_lap,
    input  logic                i_mode,
    input  logic                i_load,
    input  logic [4*DIGITS-1:0] i_load_val,
    output logic [4*DIGITS-1:0] o_count_bcd,
    output logic [4*DIGITS-1:0] o_disp_bcd,
    output logic                o_tick,
    output logic                o_wrap,
    output logic                o_running,
    output logic                o_lap,
    output logic                o_load_err
);

    localparam int W   = 4 * DIGITS;
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);

    // Convert a decimal integer into packed BCD digits, digit 0 in the low nibble.
    function automatic logic [W-1:0] to_bcd(input int unsigned v);
        logic [W-1:0] r;
        int unsigned  t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t           = t / 10;
        end
        return r;
    endfunction

    // Decimal +1 with carry rippling through the digits.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (r[4*i +: 4] >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c           = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Decimal -1 with borrow rippling through the digits.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (b) begin
                if (r[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] - 4'd1;
                    b           = 1'b0;
                end
            end
        end
        return r;
    endfunction

    localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_COUNT);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_LAP  = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic [PW-1:0]  r_p;
    logic [W-1:0]   r_count;
    logic [W-1:0]   r_lap_val;
    logic           r_wrap;
    logic           r_load_err;

    logic           w_running;
    logic           w_tick;
    logic           w_step;
    logic           w_at_end;
    logic [W-1:0]   w_count_step;
    logic           w_load_valid;
    logic           w_load_ok;
    logic           w_load_bad;

    // State register for the run/stop/lap FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_STOP;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: clear beats run_stop, which beats lap.
    always_comb begin
        w_next_state = r_state;
        if (i_clear) begin
            w_next_state = ST_STOP;
        end else if (i_run_stop) begin
            case (r_state)
                ST_STOP: w_next_state = ST_RUN;
                default: w_next_state = ST_STOP;
            endcase
        end else if (i_lap) begin
            case (r_state)
                ST_RUN:  w_next_state = ST_LAP;
                ST_LAP:  w_next_state = ST_RUN;
                default: w_next_state = r_state;
            endcase
        end
    end

    // Tick/step decode, next count value and preset validation.
    always_comb begin
        w_running    = (r_state != ST_STOP);
        w_tick       = w_running && (r_p == P_LAST);
        w_step       = w_tick && (w_next_state != ST_STOP);
        w_at_end     = i_mode ? (r_count == '0) : (r_count == MAX_BCD);
        w_count_step = i_mode ? bcd_dec(r_count) : bcd_inc(r_count);
        if (w_at_end) begin
            w_count_step = i_mode ? MAX_BCD : '0;
        end
        w_load_valid = (i_load_val <= MAX_BCD);
        for (int i = 0; i < DIGITS; i++) begin
            if (i_load_val[4*i +: 4] > 4'd9) begin
                w_load_valid = 1'b0;
            end
        end
        w_load_ok  = !i_clear && (r_state == ST_STOP) && i_load && w_load_valid;
        w_load_bad = !i_clear && (r_state == ST_STOP) && i_load && !w_load_valid;
    end

    // Prescaler: runs only while counting; a stop on the tick cycle parks it at DIV-1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_p <= '0;
        end else if (i_clear) begin
            r_p <= '0;
        end else if (w_running) begin
            if (w_step) begin
                r_p <= '0;
            end else if (!w_tick) begin
                r_p <= r_p + 1'b1;
            end
        end
    end

    // Count register with step, preset load, and the wrap / load-error pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count    <= '0;
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_wrap     <= w_step && w_at_end;
            r_load_err <= w_load_bad;
            if (i_clear) begin
                r_count <= '0;
            end else if (w_step) begin
                r_count <= w_count_step;
            end else if (w_load_ok) begin
                r_count <= i_load_val;
            end
        end
    end

    // Lap register: snapshot of the live count on entry to LAP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lap_val <= '0;
        end else if (i_clear) begin
            r_lap_val <= '0;
        end else if ((r_state == ST_RUN) && (w_next_state == ST_LAP)) begin
            r_lap_val <= r_count;
        end
    end

    assign o_count_bcd = r_count;
    assign o_disp_bcd  = (r_state == ST_LAP) ? r_lap_val : r_count;
    assign o_tick      = w_tick;
    assign o_wrap      = r_wrap;
    assign o_running   = w_running;
    assign o_lap       = (r_state == ST_LAP);
    assign o_load_err  = r_load_err;

endmodule

// File: tb/tb_bcd_updown_stopwatch.sv
// tb/tb_bcd_updown_stopwatch.sv - directed self-checking bench for bcd_updown_stopwatch
module tb_bcd_updown_stopwatch;

    logic       clk;
    logic       reset;
    logic       i_run_stop;
    logic       i_clear;
    logic       i_lap;
    logic       i_mode;
    logic       i_load;
    logic [7:0] i_load_val;
    logic [7:0] o_count_bcd;
    logic [7:0] o_disp_bcd;
    logic       o_tick;
    logic       o_wrap;
    logic       o_running;
    logic       o_lap;
    logic       o_load_err;

    int n_checks = 0;
    int n_pass   = 0;

    bcd_updown_stopwatch #(
        .DIGITS    (2),
        .MAX_COUNT (59),
        .CLK_HZ    (10),
        .TICK_HZ   (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_run_stop  (i_run_stop),
        .i_clear     (i_clear),
        .i_lap       (i_lap),
        .i_mode      (i_mode),
        .i_load      (i_load),
        .i_load_val  (i_load_val),
        .o_count_bcd (o_count_bcd),
        .o_disp_bcd  (o_disp_bcd),
        .o_tick      (o_tick),
        .o_wrap      (o_wrap),
        .o_running   (o_running),
        .o_lap       (o_lap),
        .o_load_err  (o_load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_run();
        i_run_stop = 1'b1;
        cyc(1);
        i_run_stop = 1'b0;
    endtask

    task automatic pulse_clear();
        i_clear = 1'b1;
        cyc(1);
        i_clear = 1'b0;
    endtask

    task automatic pulse_lap();
        i_lap = 1'b1;
        cyc(1);
        i_lap = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] v);
        i_load     = 1'b1;
        i_load_val = v;
        cyc(1);
        i_load     = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        i_run_stop = 1'b0;
        i_clear    = 1'b0;
        i_lap      = 1'b0;
        i_mode     = 1'b0;
        i_load     = 1'b0;
        i_load_val = 8'h00;
        cyc(3);
        chk("rst_count",   o_count_bcd, 8'h00);
        chk("rst_disp",    o_disp_bcd,  8'h00);
        chk("rst_running", o_running,   1'b0);
        chk("rst_tick",    o_tick,      1'b0);
        chk("rst_wrap",    o_wrap,      1'b0);
        chk("rst_lap",     o_lap,       1'b0);
        chk("rst_lerr",    o_load_err,  1'b0);
        reset = 1'b0;
        cyc(2);

        // Basic up-count cadence: tick when p reaches 9, count steps after it.
        pulse_run();
        chk("run_running", o_running, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            cyc(8);
            chk("pre_tick_low", o_tick, 1'b0);
            cyc(1);
            chk("tick_high", o_tick, 1'b1);
            chk("tick_count_hold", o_count_bcd, 32'(k - 1));
            cyc(1);
            chk("step_count", o_count_bcd, 32'(k));
            chk("step_tick_low", o_tick, 1'b0);
        end

        // Up wrap at MAX_COUNT.
        pulse_clear();
        chk("clr_running", o_running, 1'b0);
        do_load(8'h58);
        chk("load_58", o_count_bcd, 8'h58);
        chk("load_58_err", o_load_err, 1'b0);
        pulse_run();
        cyc(10);
        chk("up_59", o_count_bcd, 8'h59);
        chk("up_59_wrap", o_wrap, 1'b0);
        cyc(10);
        chk("up_wrap_00", o_count_bcd, 8'h00);
        chk("up_wrap_pulse", o_wrap, 1'b1);
        cyc(1);
        chk("up_wrap_gone", o_wrap, 1'b0);

        // Down wrap from 0 to MAX_COUNT (p is 1 here).
        i_mode = 1'b1;
        cyc(8);
        chk("dn_tick", o_tick, 1'b1);
        chk("dn_hold", o_count_bcd, 8'h00);
        cyc(1);
        chk("dn_wrap_59", o_count_bcd, 8'h59);
        chk("dn_wrap_pulse", o_wrap, 1'b1);
        cyc(1);
        chk("dn_wrap_gone", o_wrap, 1'b0);

        // Down borrow across digits.
        pulse_clear();
        do_load(8'h10);
        pulse_run();
        cyc(10);
        chk("borrow_09", o_count_bcd, 8'h09);
        chk("borrow_nowrap", o_wrap, 1'b0);

        // Load while running is ignored without error.
        do_load(8'h20);
        chk("load_run_ign", o_count_bcd, 8'h09);
        chk("load_run_noerr", o_load_err, 1'b0);

        // Rejected loads: above MAX_COUNT and non-BCD digit.
        pulse_clear();
        do_load(8'h60);
        chk("load_60_err", o_load_err, 1'b1);
        chk("load_60_count", o_count_bcd, 8'h00);
        cyc(1);
        chk("load_60_err_gone", o_load_err, 1'b0);
        do_load(8'h3A);
        chk("load_3a_err", o_load_err, 1'b1);
        chk("load_3a_count", o_count_bcd, 8'h00);
        cyc(1);
        chk("load_3a_err_gone", o_load_err, 1'b0);

        // Lap in STOP is ignored.
        pulse_lap();
        chk("lap_stop_ign", o_lap, 1'b0);
        chk("lap_stop_run", o_running, 1'b0);

        // Lap freeze while counting continues.
        i_mode = 1'b0;
        pulse_run();
        cyc(50);
        chk("lap_pre_05", o_count_bcd, 8'h05);
        pulse_lap();
        chk("lap_on", o_lap, 1'b1);
        chk("lap_disp_05", o_disp_bcd, 8'h05);
        cyc(29);
        chk("lap_live_08", o_count_bcd, 8'h08);
        chk("lap_hold_05", o_disp_bcd, 8'h05);
        pulse_lap();
        chk("lap_off", o_lap, 1'b0);
        chk("lap_release_08", o_disp_bcd, 8'h08);
        chk("lap_off_running", o_running, 1'b1);
        pulse_lap();
        chk("lap2_on", o_lap, 1'b1);
        pulse_run();
        chk("lap_stop_running", o_running, 1'b0);
        chk("lap_stop_lap", o_lap, 1'b0);
        chk("lap_stop_disp", o_disp_bcd, 8'h08);

        // Stop at p=4 and resume the partial period.
        pulse_clear();
        pulse_run();
        cyc(4);
        pulse_run();
        cyc(3);
        chk("stopped_count", o_count_bcd, 8'h00);
        pulse_run();
        cyc(3);
        chk("resume_no_tick", o_tick, 1'b0);
        cyc(1);
        chk("resume_tick", o_tick, 1'b1);
        cyc(1);
        chk("resume_step", o_count_bcd, 8'h01);

        // Stop on the tick cycle suppresses the step; restart ticks at once.
        cyc(9);
        chk("supp_tick", o_tick, 1'b1);
        pulse_run();
        chk("supp_count", o_count_bcd, 8'h01);
        chk("supp_stopped", o_running, 1'b0);
        chk("supp_tick_off", o_tick, 1'b0);
        pulse_run();
        chk("supp_restart_tick", o_tick, 1'b1);
        cyc(1);
        chk("supp_restart_step", o_count_bcd, 8'h02);

        // Clear together with run_stop while running.
        i_clear    = 1'b1;
        i_run_stop = 1'b1;
        cyc(1);
        i_clear    = 1'b0;
        i_run_stop = 1'b0;
        chk("clr_rs_count", o_count_bcd, 8'h00);
        chk("clr_rs_running", o_running, 1'b0);

        // Reset mid-run at count 0x37, p=7.
        do_load(8'h37);
        pulse_run();
        cyc(7);
        chk("pre_rst_count", o_count_bcd, 8'h37);
        reset = 1'b1;
        #1;
        chk("async_rst_count", o_count_bcd, 8'h00);
        chk("async_rst_running", o_running, 1'b0);
        chk("async_rst_tick", o_tick, 1'b0);
        cyc(1);
        reset = 1'b0;
        cyc(15);
        chk("post_rst_idle", o_count_bcd, 8'h00);
        chk("post_rst_notick", o_tick, 1'b0);
        pulse_run();
        cyc(8);
        chk("post_rst_pre", o_tick, 1'b0);
        cyc(1);
        chk("post_rst_tick", o_tick, 1'b1);
        cyc(1);
        chk("post_rst_step", o_count_bcd, 8'h01);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
